// File: rtl/cond_pkg.sv
// Shared types and the ARM condition-code decode for the execute-stage condition unit.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FG_NZ = 1;
  localparam int FG_CV = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input flags_t f);
    logic p;
    p = 1'b0;
    case (cond_e'(cond))
      EQ: p = f.z;
      NE: p = ~f.z;
      CS: p = f.c;
      CC: p = ~f.c;
      MI: p = f.n;
      PL: p = ~f.n;
      VS: p = f.v;
      VC: p = ~f.v;
      HI: p = f.c & ~f.z;
      LS: p = ~f.c | f.z;
      GE: p = (f.n == f.v);
      LT: p = (f.n != f.v);
      GT: p = ~f.z & (f.n == f.v);
      LE: p = f.z | (f.n != f.v);
      AL: p = 1'b1;
      NV: p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cond_flag_stack.sv
// LIFO of saved flag words for exception entry/return, with a sticky misuse error.
module cond_flag_stack
  import cond_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   err_clr,
  input  flags_t din,
  output flags_t top,
  output logic   pop_ok,
  output logic   full,
  output logic   empty,
  output logic   err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t          mem [DEPTH];
  logic   [CW-1:0] count;
  logic   [PW-1:0] wr_idx;
  logic   [PW-1:0] rd_idx;
  logic            push_ok;
  logic            new_err;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = PW'(count);
  assign rd_idx  = PW'(count - CW'(1));
  assign top     = mem[rd_idx];

  // Simultaneous push and pop is treated as misuse: neither takes effect.
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign new_err = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_idx] <= din;
        count       <= count + CW'(1);
      end else if (pop_ok) begin
        count       <= count - CW'(1);
      end
      if (new_err)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage condition unit: gates PC/reg/mem writes by the condition field and owns NZCV.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter bit REG_OUT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       push_flags,
  input  logic       pop_flags,
  input  logic       err_clr,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic [3:0] flags_o,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  flags_t     flags_q;
  flags_t     flags_wr;
  flags_t     flags_d;
  flags_t     stack_top;
  logic       stack_pop_ok;
  logic       en;
  logic [3:0] gated;

  assign en    = in_valid & cond_pass(cond, flags_q) & ~stall & ~flush;
  assign gated = {pcs & en, reg_w & en, mem_w & en, en};

  always_comb begin
    flags_wr = flags_q;
    if (en & flag_w[FG_NZ]) begin
      flags_wr.n = alu_flags[FLAG_N];
      flags_wr.z = alu_flags[FLAG_Z];
    end
    if (en & flag_w[FG_CV]) begin
      flags_wr.c = alu_flags[FLAG_C];
      flags_wr.v = alu_flags[FLAG_V];
    end
  end

  // A successful pop restores both groups and wins over this cycle's ALU write.
  assign flags_d = stack_pop_ok ? stack_top : flags_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flags_q <= '0;
    else      flags_q <= flags_d;
  end

  assign flags_o = flags_q;

  cond_flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push_flags),
    .pop     (pop_flags),
    .err_clr (err_clr),
    .din     (flags_wr),
    .top     (stack_top),
    .pop_ok  (stack_pop_ok),
    .full    (stack_full),
    .empty   (stack_empty),
    .err     (stack_err)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic [3:0] out_q;
      // Stall and flush both force en low, so the register loads zeros and never repeats a write.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_q <= '0;
        else      out_q <= gated;
      end
      assign {pc_src, reg_write, mem_write, cond_ex} = out_q;
    end else begin : g_comb
      assign {pc_src, reg_write, mem_write, cond_ex} = gated;
    end
  endgenerate

endmodule

// File: doc/cond_unit_pipe.md
Name: cond_unit_pipe

Overview:
Next-generation condition unit for the ARMv4 core. It evaluates the 4-bit condition field against the architectural NZCV flags and gates PC, register and memory write enables. It holds the flags in two independently writable groups. It adds pipeline stall/flush handling, an optional registered output stage (EX->MEM), and a parametrised LIFO that saves and restores flags on exception entry and return. It sits in the execute stage, between the decoder control bits and the ALU flag outputs.

Parameters:
STACK_DEPTH, 4, number of flag-save entries in the LIFO (>=1).
REG_OUT, 1, 1 = gated enables and cond_ex are registered one cycle; 0 = combinational.

Ports:
clk  in  1  core clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
in_valid  in  1  an instruction is present in this stage.
stall  in  1  pipeline stall: hold all state except the flag stack.
flush  in  1  squash the current instruction.
cond  in  4  instruction condition field [31:28].
alu_flags  in  4  ALU result flags {N,Z,C,V}.
flag_w  in  2  flag-write request: [1] = NZ group, [0] = CV group.
pcs  in  1  instruction writes PC.
reg_w  in  1  instruction writes the register file.
mem_w  in  1  instruction writes memory.
push_flags  in  1  save flags (exception entry).
pop_flags  in  1  restore flags (exception return).
err_clr  in  1  clear the sticky stack error.
pc_src  out  1  gated PC write.
reg_write  out  1  gated register write.
mem_write  out  1  gated memory write.
cond_ex  out  1  condition passed for a valid, unstalled, unflushed instruction.
flags_o  out  4  current architectural flags {N,Z,C,V}.
stack_full  out  1  LIFO holds STACK_DEPTH entries.
stack_empty  out  1  LIFO holds 0 entries.
stack_err  out  1  sticky overflow/underflow indicator.

Behaviour:
- Condition decode, standard ARM, evaluated against the registered flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- en = in_valid & pass & ~stall & ~flush; cond_ex = en.
- pc_src = pcs & en; reg_write = reg_w & en; mem_write = mem_w & en.
- Flags update on the edge: group NZ [3:2] loads alu_flags[3:2] when flag_w[1] & en; group CV [1:0] loads alu_flags[1:0] when flag_w[0] & en.
- No flag forwarding: an instruction sees flags written by the previous instruction's edge, so back-to-back CMP then BEQ works with one cycle spacing.
- REG_OUT=1: the four gated outputs are registered.
  - flush clears the register to 0 on the next edge.
  - stall loads 0, so no duplicate writes occur.
  - Latency is 1 cycle.
- REG_OUT=0: the outputs are combinational, with 0 latency.
- Flag stack (independent of stall/flush):
  - Push with count<DEPTH: stores the flags' next value (including any same-cycle flag write) at top; count+1.
  - Pop with count>0: loads top into both flag groups, overriding any same-cycle flag write; count-1.
  - Push when full: dropped, stack_err set, flags unaffected.
  - Pop when empty: flags unchanged, stack_err set.
  - push & pop in the same cycle: both ignored, stack_err set.
  - stack_err is sticky. It clears on err_clr (err_clr loses to a same-cycle new error) or on reset.
- stack_full = (count==DEPTH); stack_empty = (count==0).
- Reset (rst=0, asynchronous): flags=0000, count=0, stack entries=0, stack_err=0, registered outputs=0.
- Reset mid-push/pop discards the operation.

Decomposition:
- Package cond_pkg:
  - cond_e enum with 16 codes EQ..NV.
  - flags_t typedef as a packed struct {n,z,c,v}.
  - Constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Constants FG_NZ=1, FG_CV=0.
- Sub-module cond_flag_stack: parametrised LIFO (depth, count, full/empty, error flag). The condition decode is a function in cond_pkg.

Test Plan:
- Reset, then cond=E, in_valid=1, reg_w=1, alu_flags=0100, flag_w=10 -> reg_write=1 after REG_OUT latency; next cycle flags_o=0100; cond=0 (EQ) gives cond_ex=1, cond=1 (NE) gives 0.
- flags_o=1000 (N=1, V=0), cond=B (LT) with mem_w=1, stall=1 -> mem_write=0 and flags unchanged; stall=0 -> mem_write=1.
- flag_w=01 with alu_flags=1111 from flags 0000 -> flags_o=0011 (NZ untouched); cond=F with pcs=1 -> pc_src=0 for any flags.
- Flags 1010, push; write 0101; pop -> flags_o=1010, stack_empty=1. Push and flag_w=11 with alu 0001 in the same cycle -> stacked value 0001.
- STACK_DEPTH=4: 5 pushes -> stack_full=1, stack_err=1 after the 5th, count stays 4; err_clr -> 0; 5 pops -> stack_err=1 on the 5th, flags equal the 1st pushed value.
- Assert flush with REG_OUT=1 and a passing reg_w -> reg_write=0 next cycle. Assert rst low mid-sequence -> all outputs 0 asynchronously.
